// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, buffers fetched words in a small FIFO for decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fault and halt fetch.
module fetch_unit #(
   parameter int unsigned IMEM_BYTES = 64,
   parameter logic [63:0] RESET_PC   = 64'd0,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        br_valid,
   input  logic [63:0] br_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [63:0] id_pc,
   output logic        halted,
   output logic        fault
);

   localparam int unsigned   PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [63:0]   IMEM_END = 64'(IMEM_BYTES);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   logic [63:0]      pc_q, pc_d;
   logic             halted_q, halted_d;
   logic             fault_q, fault_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic [31:0]      instr_q [FIFO_DEPTH];
   logic [63:0]      pcbuf_q [FIFO_DEPTH];

   logic        pop, push, misalign;
   logic [63:0] tgt_al, pc_inc;

   assign tgt_al = br_target & ~64'd3;
   assign pc_inc = pc_q + 64'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign = (br_target[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign id_valid  = (cnt_q != '0);
   assign pop       = id_valid & id_ready;
   assign push      = !halted_q & !br_valid & ((cnt_q != CNT_FULL) | pop);
   assign imem_addr = pc_q;
   assign id_instr  = instr_q[rd_ptr_q];
   assign id_pc     = pcbuf_q[rd_ptr_q];
   assign halted    = halted_q;
   assign fault     = fault_q;

   always_comb begin
      pc_d     = pc_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (br_valid) begin
         // Redirect wins over push and pop: the buffer is simply emptied.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         pc_d     = tgt_al;
         if (misalign) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
         end else begin
            halted_d = fault_q | (tgt_al >= IMEM_END);
         end
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = pc_inc;
            if (pc_inc >= IMEM_END) halted_d = 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is cleared on reset so id_instr/id_pc read as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            instr_q[i] <= '0;
            pcbuf_q[i] <= '0;
         end
      end else if (push) begin
         instr_q[wr_ptr_q] <= imem_instr;
         pcbuf_q[wr_ptr_q] <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;

   localparam int unsigned IMEM_BYTES = 64;
   localparam int unsigned DEPTH      = 2;
   localparam logic [63:0] RST_PC     = 64'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        br_valid = 1'b0;
   logic [63:0] br_target = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
   logic        halted;
   logic        fault;

   logic [31:0] imem [16];

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_pc;
   logic        m_halted;
   logic        m_fault;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   fetch_unit #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .br_valid(br_valid), .br_target(br_target), .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < 64'(IMEM_BYTES)) ? imem[imem_addr[5:2]] : 32'h0;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return imem[a[5:2]];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc     = RST_PC;
      m_halted = 1'b0;
      m_fault  = 1'b0;
   endtask

   // Applies the fetch rules for one rising edge given the inputs now on the pins.
   task automatic model_edge();
      bit do_pop, do_push;
      ent_t e;
      if (br_valid) begin
         mq.delete();
         m_pc = {br_target[63:2], 2'b00};
         if (TRAP && br_target[1:0] != 2'b00) begin
            m_fault  = 1'b1;
            m_halted = 1'b1;
         end else begin
            m_halted = m_fault || (m_pc >= 64'(IMEM_BYTES));
         end
      end else begin
         do_pop  = (mq.size() != 0) && id_ready;
         do_push = !m_halted && ((mq.size() < DEPTH) || do_pop);
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.pc  = m_pc;
            e.ins = word_at(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 64'd4;
            if (m_pc >= 64'(IMEM_BYTES)) m_halted = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      chk("id_valid", 64'(id_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("id_pc", id_pc, mq[0].pc);
         chk("id_instr", 64'(id_instr), 64'(mq[0].ins));
      end
      chk("imem_addr", imem_addr, m_pc);
      chk("halted", 64'(halted), 64'(m_halted));
      chk("fault", 64'(fault), 64'(m_fault));
   endtask

   task automatic step(input logic rdy, input logic br, input logic [63:0] tgt);
      id_ready  = rdy;
      br_valid  = br;
      br_target = tgt;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      id_ready = 1'b0;
      br_valid = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) imem[i] = $urandom;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_instr", 64'(id_instr), 64'd0);
      chk("rst_id_pc", id_pc, 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_imem_addr", imem_addr, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;

      // Straight stream after release
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

      // Backpressure from reset, then drain
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
      chk("bp_imem_addr", imem_addr, 64'd8);
      chk("bp_id_pc", id_pc, 64'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

      // Redirect while full
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 64'h20);
      chk("redir_imem_addr", imem_addr, 64'h20);
      step(1'b1, 1'b0, '0);
      chk("redir_id_pc", id_pc, 64'h20);

      // Run off the end of memory, then restart
      step(1'b1, 1'b1, 64'h0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);
      chk("end_halted", 64'(halted), 64'd1);
      chk("end_imem_addr", imem_addr, 64'd64);
      step(1'b1, 1'b1, 64'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 64'h40);
      step(1'b1, 1'b0, '0);

      // Random traffic with aligned targets, some out of range
      for (int i = 0; i < 300; i++) begin
         logic br;
         br = ($urandom_range(0, 9) == 0);
         step(logic'($urandom_range(0, 3) != 0), br, {58'd0, 4'($urandom_range(0, 15)), 2'b00} +
              (($urandom_range(0, 4) == 0) ? 64'd16 : 64'd0));
      end

      // Misaligned redirect
      step(1'b1, 1'b1, 64'h22);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 64'h4);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

      // Asynchronous reset with a full buffer
      do_reset();
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_id_valid", 64'(id_valid), 64'd0);
      chk("async_imem_addr", imem_addr, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

      // Random traffic including misaligned targets
      for (int i = 0; i < 200; i++) begin
         step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 11) == 0),
              64'($urandom_range(0, 70)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
